alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Sequential front end for the 32-bit ALU (ports a, b, CI, F, dir, bite, S, CO).
- Accepts tagged operation commands over a valid/ready interface and drives the ALU operand/control inputs.
- Waits a fixed settle time, then captures S/CO into a result FIFO and returns them over a valid/ready response interface.
- Replaces hand-timed stimulus with a handshaked command/response path for system use and self-checking benches.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYC, 2, cycles the ALU inputs are held before capture; legal range 1..15.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- TAG_W, 4, command tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&&ready at a clk edge.
- cmd_a  in  WIDTH  operand a.
- cmd_b  in  WIDTH  operand b.
- cmd_ci  in  1  carry in.
- cmd_f  in  3  opcode: 000 zero, 001 add, 010 shift/rotate, 011 truncate, 100 and, 101 or, 110 not, 111 xor.
- cmd_dir  in  2  shift/truncate direction.
- cmd_bite  in  5  shift/truncate amount.
- cmd_tag  in  TAG_W  user tag returned with the result.
- alu_a, alu_b  out  WIDTH  to ALU a, b.
- alu_ci  out  1  to ALU CI.
- alu_f  out  3  to ALU F.
- alu_dir  out  2  to ALU dir.
- alu_bite  out  5  to ALU bite.
- alu_s  in  WIDTH  from ALU S.
- alu_co  in  1  from ALU CO.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer pops the head when valid&&ready.
- rsp_s  out  WIDTH  captured S.
- rsp_co  out  1  captured CO.
- rsp_f  out  3  opcode of the result.
- rsp_tag  out  TAG_W  tag of the result.
- rsp_err  out  1  reference mismatch; see Optional Feature.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, settle counter 0, FIFO emptied.
- Reset values: all alu_* outputs 0; rsp_valid 0; rsp_s/rsp_co/rsp_f/rsp_tag/rsp_err 0; busy 0. cmd_ready is 1 after reset, since the block is IDLE with an empty FIFO.
- Reset mid-operation discards the in-flight command and all FIFO contents; no response is ever produced for them.
- FSM IDLE -> SETTLE -> CAPTURE -> IDLE:
  - IDLE: cmd_ready = !fifo_full. On accept at edge T0, register all cmd_* fields onto alu_* outputs, latch tag and opcode, load counter = SETTLE_CYC-1, go to SETTLE.
  - SETTLE: hold alu_*; decrement the counter each cycle; at 0 go to CAPTURE.
  - CAPTURE: at this edge, sample alu_s/alu_co into the FIFO together with the tag and opcode, then go to IDLE.
- Timing: capture edge = T0+SETTLE_CYC. The next accept is at T0+SETTLE_CYC+1 at the earliest. Throughput is one command per SETTLE_CYC+1 cycles.
- alu_* outputs keep the last command's values between operations; they do not return to 0.
- FIFO is show-ahead: rsp_* reflect the head whenever rsp_valid=1. An entry pushed at edge Tc is visible from Tc (if the FIFO was empty) and can be popped at Tc+1 at the earliest.
- Simultaneous push and pop: both happen; the count is unchanged.
- Full FIFO cannot receive a capture, because an accept requires not-full and the count can only decrease until the capture. cmd_ready stays low while the FIFO is full.
- Pointers wrap modulo FIFO_DEPTH; the count is tracked with one extra bit.
- cmd_* fields are ignored when no handshake occurs. rsp_ready is ignored when rsp_valid=0.

Optional Feature:
- ALU_REF_CHECK_EN defined: an internal model computes the expected result at capture:
  - add: {CO,S} = a+b+CI.
  - and/or/xor: bitwise; CO=0.
  - not: S = ~a; CO=0.
  - rsp_err = 1 if captured {CO,S} differs from expected. The flag is stored per entry.
  - Opcodes 000/010/011 are never flagged.
- Undefined: no model is built; rsp_err is tied to 0.

Test Plan:
- Add: a=0x7F, b=0x1F, CI=0, F=001, SETTLE_CYC=2 -> rsp_s=0x9E, rsp_co=0, rsp_tag echoed, capture exactly 2 cycles after accept.
- Carry: a=0xFFFFFFFF, b=0, CI=1, F=001 -> rsp_s=0, rsp_co=1.
- Logic sequence, tags 1..4 back-to-back with rsp_ready=1:
  - AND 0x7F&0x70 -> 0x70.
  - OR 0x76|0x30 -> 0x76.
  - NOT 0x7F -> 0xFFFFFF80.
  - XOR 0xFF^0x47 -> 0xB8.
  - Responses arrive in order; cmd_ready spacing is 3 cycles.
- Backpressure: rsp_ready=0, issue 5 commands -> 4 accepted, cmd_ready low once full; raise rsp_ready -> 4 pops in order, then the 5th is accepted.
- Reset mid-SETTLE: assert rst_n=0 during SETTLE with 2 entries queued -> immediate rsp_valid=0, alu_*=0, busy=0; no stale response after release.
- With ALU_REF_CHECK_EN: ALU model forced to return 0x9F for add 0x7F+0x1F -> rsp_err=1. Shift command with dir=01, bite=7 -> rsp_err=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Handshaked command/response front end for the 32-bit ALU: drives operands, waits a settle
// time, captures S/CO into a show-ahead result FIFO. Define ALU_REF_CHECK_EN for a result reference check.
module alu_cmd_sequencer #(
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_ci,
    input  logic [2:0]       cmd_f,
    input  logic [1:0]       cmd_dir,
    input  logic [4:0]       cmd_bite,
    input  logic [TAG_W-1:0] cmd_tag,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_ci,
    output logic [2:0]       alu_f,
    output logic [1:0]       alu_dir,
    output logic [4:0]       alu_bite,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_co,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_co,
    output logic [2:0]       rsp_f,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,

    output logic             busy
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_alu_ci;
    logic [2:0]       r_alu_f;
    logic [1:0]       r_alu_dir;
    logic [4:0]       r_alu_bite;
    logic [TAG_W-1:0] r_tag;

    logic [WIDTH-1:0] r_mem_s   [FIFO_DEPTH];
    logic             r_mem_co  [FIFO_DEPTH];
    logic [2:0]       r_mem_f   [FIFO_DEPTH];
    logic [TAG_W-1:0] r_mem_tag [FIFO_DEPTH];
    logic             r_mem_err [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_err;

    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = (r_state == S_IDLE) && !w_full;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_push    = (r_state == S_CAPTURE);
    assign w_pop     = rsp_valid && rsp_ready;
    assign busy      = (r_state != S_IDLE);

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_ci   = r_alu_ci;
    assign alu_f    = r_alu_f;
    assign alu_dir  = r_alu_dir;
    assign alu_bite = r_alu_bite;

    // The SETTLE->CAPTURE step is taken on the edge where the counter would reach 0, so
    // the capture edge lands exactly SETTLE_CYC edges after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_ci   <= 1'b0;
            r_alu_f    <= '0;
            r_alu_dir  <= '0;
            r_alu_bite <= '0;
            r_tag      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a    <= cmd_a;
                        r_alu_b    <= cmd_b;
                        r_alu_ci   <= cmd_ci;
                        r_alu_f    <= cmd_f;
                        r_alu_dir  <= cmd_dir;
                        r_alu_bite <= cmd_bite;
                        r_tag      <= cmd_tag;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= (SETTLE_CYC == 1) ? S_CAPTURE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1)
                        r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: every read is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_s[r_wr_ptr]   <= alu_s;
            r_mem_co[r_wr_ptr]  <= alu_co;
            r_mem_f[r_wr_ptr]   <= r_alu_f;
            r_mem_tag[r_wr_ptr] <= r_tag;
            r_mem_err[r_wr_ptr] <= w_err;
        end
    end

    assign rsp_valid = !w_empty;
    assign rsp_s     = rsp_valid ? r_mem_s[r_rd_ptr]   : '0;
    assign rsp_co    = rsp_valid ? r_mem_co[r_rd_ptr]  : 1'b0;
    assign rsp_f     = rsp_valid ? r_mem_f[r_rd_ptr]   : '0;
    assign rsp_tag   = rsp_valid ? r_mem_tag[r_rd_ptr] : '0;
    assign rsp_err   = rsp_valid ? r_mem_err[r_rd_ptr] : 1'b0;

`ifdef ALU_REF_CHECK_EN
    logic [WIDTH:0] w_ref;
    logic           w_ref_chk;

    // Zero, shift/rotate and truncate are not modelled and never flagged.
    always_comb begin
        w_ref     = '0;
        w_ref_chk = 1'b1;
        case (r_alu_f)
            3'b001:  w_ref = {1'b0, r_alu_a} + {1'b0, r_alu_b} + {{WIDTH{1'b0}}, r_alu_ci};
            3'b100:  w_ref = {1'b0, r_alu_a & r_alu_b};
            3'b101:  w_ref = {1'b0, r_alu_a | r_alu_b};
            3'b110:  w_ref = {1'b0, ~r_alu_a};
            3'b111:  w_ref = {1'b0, r_alu_a ^ r_alu_b};
            default: w_ref_chk = 1'b0;
        endcase
    end

    assign w_err = w_ref_chk && ({alu_co, alu_s} != w_ref);
`else
    assign w_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stand-in.
module tb_alu_cmd_sequencer;

`ifdef ALU_REF_CHECK_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        cmd_ci = 1'b0;
    logic [2:0]  cmd_f = '0;
    logic [1:0]  cmd_dir = '0;
    logic [4:0]  cmd_bite = '0;
    logic [3:0]  cmd_tag = '0;
    logic [31:0] alu_a, alu_b, alu_s;
    logic        alu_ci, alu_co;
    logic [2:0]  alu_f;
    logic [1:0]  alu_dir;
    logic [4:0]  alu_bite;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_s;
    logic        rsp_co;
    logic [2:0]  rsp_f;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;
    logic        bad_add = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    alu_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ci(cmd_ci), .cmd_f(cmd_f),
        .cmd_dir(cmd_dir), .cmd_bite(cmd_bite), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_f(alu_f),
        .alu_dir(alu_dir), .alu_bite(alu_bite), .alu_s(alu_s), .alu_co(alu_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_co(rsp_co),
        .rsp_f(rsp_f), .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in; bad_add corrupts the add result to exercise the reference check
    always_comb begin
        {alu_co, alu_s} = '0;
        case (alu_f)
            3'b001: {alu_co, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_ci};
            3'b010: alu_s = alu_dir[0] ? (alu_a << alu_bite) : (alu_a >> alu_bite);
            3'b011: alu_s = alu_a >> alu_bite;
            3'b100: alu_s = alu_a & alu_b;
            3'b101: alu_s = alu_a | alu_b;
            3'b110: alu_s = ~alu_a;
            3'b111: alu_s = alu_a ^ alu_b;
            default: ;
        endcase
        if (bad_add && alu_f == 3'b001) begin
            alu_s  = 32'h0000_009F;
            alu_co = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic ci,
                            input logic [2:0] f, input logic [1:0] dir, input logic [4:0] bite,
                            input logic [3:0] tag, output longint t_acc);
        int waited = 0;
        cmd_a = a; cmd_b = b; cmd_ci = ci; cmd_f = f;
        cmd_dir = dir; cmd_bite = bite; cmd_tag = tag;
        cmd_valid = 1'b1;
        t_acc = 0;
        while (!cmd_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    // Called at a negedge; waits for a head entry, checks it, and steps past its pop.
    task automatic expect_rsp(input string tag, input logic [31:0] s, input logic co,
                              input logic [2:0] f, input logic [3:0] t, input logic err);
        int waited = 0;
        while (!rsp_valid && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_s"},     64'(rsp_s),     64'(s));
        check({tag, "_co"},    64'(rsp_co),    64'(co));
        check({tag, "_f"},     64'(rsp_f),     64'(f));
        check({tag, "_tag"},   64'(rsp_tag),   64'(t));
        check({tag, "_err"},   64'(rsp_err),   64'(err));
        if (rsp_ready) @(negedge clk);
    endtask

    initial begin
        longint t0;
        longint t_seq [4];
        int     seen;

        #2;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_alu_a",     64'(alu_a),     64'd0);
        check("rst_alu_f",     64'(alu_f),     64'd0);
        check("rst_rsp_s",     64'(rsp_s),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add, with exact capture latency
        send_cmd(32'h7F, 32'h1F, 1'b0, 3'b001, 2'b00, 5'd0, 4'h3, t0);
        check("add_busy",      64'(busy),      64'd1);
        check("add_alu_a",     64'(alu_a),     64'h7F);
        @(negedge clk);
        check("add_early_vld", 64'(rsp_valid), 64'd0);
        check("add_ready_hold", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("add_cap_vld",   64'(rsp_valid), 64'd1);
        check("add_idle",      64'(busy),      64'd0);
        rsp_ready = 1'b1;
        expect_rsp("add", 32'h9E, 1'b0, 3'b001, 4'h3, 1'b0);
        check("add_drained",   64'(rsp_valid), 64'd0);

        // Carry out
        send_cmd(32'hFFFF_FFFF, 32'h0, 1'b1, 3'b001, 2'b00, 5'd0, 4'hA, t0);
        expect_rsp("carry", 32'h0, 1'b1, 3'b001, 4'hA, 1'b0);

        // Back-to-back logic ops, consumer always ready
        fork
            begin
                send_cmd(32'h7F, 32'h70, 1'b0, 3'b100, 2'b00, 5'd0, 4'h1, t_seq[0]);
                send_cmd(32'h76, 32'h30, 1'b0, 3'b101, 2'b00, 5'd0, 4'h2, t_seq[1]);
                send_cmd(32'h7F, 32'h00, 1'b0, 3'b110, 2'b00, 5'd0, 4'h3, t_seq[2]);
                send_cmd(32'hFF, 32'h47, 1'b0, 3'b111, 2'b00, 5'd0, 4'h4, t_seq[3]);
            end
            begin
                expect_rsp("and", 32'h70,        1'b0, 3'b100, 4'h1, 1'b0);
                expect_rsp("or",  32'h76,        1'b0, 3'b101, 4'h2, 1'b0);
                expect_rsp("not", 32'hFFFFFF80,  1'b0, 3'b110, 4'h3, 1'b0);
                expect_rsp("xor", 32'hB8,        1'b0, 3'b111, 4'h4, 1'b0);
            end
        join
        for (int i = 1; i < 4; i++)
            check($sformatf("seq_spacing%0d", i), 64'(t_seq[i] - t_seq[i-1]), 64'd30);

        // Backpressure: fill the FIFO, fifth command must stall until a pop
        rsp_ready = 1'b0;
        @(negedge clk);
        send_cmd(32'h1,         32'h2,        1'b0, 3'b001, 2'b00, 5'd0, 4'h5, t0);
        send_cmd(32'h10,        32'h20,       1'b1, 3'b001, 2'b00, 5'd0, 4'h6, t0);
        send_cmd(32'hF0F0,      32'h0FF0,     1'b0, 3'b111, 2'b00, 5'd0, 4'h7, t0);
        send_cmd(32'h100,       32'h001,      1'b0, 3'b101, 2'b00, 5'd0, 4'h8, t0);
        @(negedge clk);
        @(negedge clk);
        cmd_a = 32'hFFFF0000; cmd_b = 32'h12345678; cmd_f = 3'b100; cmd_tag = 4'h9;
        cmd_valid = 1'b1;
        check("bp_full_ready", 64'(cmd_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("bp_still_stall", 64'(cmd_ready), 64'd0);
        check("bp_head_tag",    64'(rsp_tag),   64'h5);
        fork
            send_cmd(32'hFFFF0000, 32'h12345678, 1'b0, 3'b100, 2'b00, 5'd0, 4'h9, t0);
            begin
                rsp_ready = 1'b1;
                expect_rsp("bp0", 32'h3,        1'b0, 3'b001, 4'h5, 1'b0);
                expect_rsp("bp1", 32'h31,       1'b0, 3'b001, 4'h6, 1'b0);
                expect_rsp("bp2", 32'hFF00,     1'b0, 3'b111, 4'h7, 1'b0);
                expect_rsp("bp3", 32'h101,      1'b0, 3'b101, 4'h8, 1'b0);
                expect_rsp("bp4", 32'h12340000, 1'b0, 3'b100, 4'h9, 1'b0);
            end
        join

        // Reference check: corrupted add is flagged only when the model is built; shifts never
        bad_add = 1'b1;
        send_cmd(32'h7F, 32'h1F, 1'b0, 3'b001, 2'b00, 5'd0, 4'hB, t0);
        expect_rsp("ref_add", 32'h9F, 1'b0, 3'b001, 4'hB, REF_EN);
        bad_add = 1'b0;
        send_cmd(32'h1, 32'h0, 1'b0, 3'b010, 2'b01, 5'd7, 4'hC, t0);
        expect_rsp("ref_shift", 32'h80, 1'b0, 3'b010, 4'hC, 1'b0);

        // Reset during SETTLE with two entries queued
        rsp_ready = 1'b0;
        send_cmd(32'h5, 32'h6, 1'b0, 3'b001, 2'b00, 5'd0, 4'hD, t0);
        send_cmd(32'h7, 32'h8, 1'b0, 3'b001, 2'b00, 5'd0, 4'hE, t0);
        send_cmd(32'h9, 32'hA, 1'b0, 3'b001, 2'b00, 5'd0, 4'hF, t0);
        check("mid_busy",  64'(busy),      64'd1);
        check("mid_queued", 64'(rsp_tag),  64'hD);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_alu_a", 64'(alu_a),     64'd0);
        check("mid_rst_alu_b", 64'(alu_b),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("post_rst_stale", 64'(seen), 64'd0);
        check("post_rst_ready", 64'(cmd_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
